// File: rtl/picomips_pkg.sv
// Shared picoMIPS instruction encoding: opcodes and field positions.
package picomips_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_ADDI = 2'b01,
    OP_MULI = 2'b10,
    OP_B    = 2'b11
  } opcode_t;

  localparam int OPC_HI   = 13;
  localparam int OPC_LO   = 12;
  localparam int IMM_HI   = 7;
  localparam int COND_BIT = 7;

  // True when the opcode field selects the conditional branch
  function automatic logic is_branch(input logic [1:0] opc);
    return opcode_t'(opc) == OP_B;
  endfunction

endpackage

// File: rtl/pc_branch_seq_sw_debounce.sv
// Switch synchroniser and debouncer: sw_go is asynchronous to clk, so it is
// first passed through a flop chain, then must hold a new level for
// DB_CYCLES consecutive clocks before the debounced level follows it.
module sw_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_go,
  output logic sw_db
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_db;
  logic                   w_s;

  assign w_s   = r_sync[SYNC_STAGES-1];
  assign sw_db = r_db;

  // Synchroniser chain, shifts every clock regardless of PC enable
  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], sw_go};
  end

  // Count consecutive disagreeing samples; any agreeing sample drops the run
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (w_s == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_db  <= w_s;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pc_branch_seq.sv
// picoMIPS program counter and branch sequencer. Drives the program ROM
// address; a B instruction jumps to its immediate target when the debounced
// switch matches the instruction's condition bit, otherwise the PC increments.
module pc_branch_seq
  import picomips_pkg::*;
#(
  parameter int Psize       = 5,
  parameter int Isize       = 14,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Isize-1:0] I,
  input  logic             sw_go,
  input  logic             en,
  output logic [Psize-1:0] address,
  output logic             branch_taken,
  output logic             spin,
  output logic             sw_db
);

  logic             w_is_b;
  logic             w_cond;
  logic [Psize-1:0] w_target;
  logic [Psize-1:0] w_next_pc;
  logic [Psize-1:0] r_pc;
  logic             w_unused;

  // rd/rs fields and high immediate bits play no part in sequencing
  assign w_unused = &{1'b0, I};

  sw_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES)
  ) u_db (
    .clk  (clk),
    .reset(reset),
    .sw_go(sw_go),
    .sw_db(sw_db)
  );

  assign w_is_b       = is_branch(I[OPC_HI:OPC_LO]);
  assign w_cond       = I[COND_BIT];
  assign w_target     = I[Psize-1:0];
  assign branch_taken = w_is_b && (sw_db == w_cond);
  assign spin         = branch_taken && (w_target == r_pc);
  assign address      = r_pc;

  // Next-PC select: hold when disabled, jump on taken branch, else wrap-increment
  always_comb begin
    w_next_pc = r_pc;
    if (en) begin
      if (branch_taken) w_next_pc = w_target;
      else              w_next_pc = r_pc + 1'b1;
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (reset) r_pc <= '0;
    else       r_pc <= w_next_pc;
  end

endmodule

// File: tb/tb_pc_branch_seq.sv
// Self-checking bench for pc_branch_seq: reset, a directed vector table,
// hand-written multi-cycle sequences and a randomised run against a model.
module tb_pc_branch_seq;

  localparam int PS = 5;
  localparam int IS = 14;
  localparam int SS = 2;
  localparam int DB = 4;

  localparam logic [13:0] ADD = 14'h0000;

  logic          clk = 1'b0;
  logic          reset;
  logic [IS-1:0] I;
  logic          sw_go;
  logic          en;
  logic [PS-1:0] address;
  logic          branch_taken;
  logic          spin;
  logic          sw_db;

  int total = 0;
  int bad   = 0;

  pc_branch_seq #(.Psize(PS), .Isize(IS), .SYNC_STAGES(SS), .DB_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .I(I), .sw_go(sw_go), .en(en),
    .address(address), .branch_taken(branch_taken), .spin(spin), .sw_db(sw_db)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        sw;
    logic [13:0] ins;
    logic        exp_tk;
    logic        exp_sp;
    logic [4:0]  exp_addr;
    logic        exp_db;
  } vec_t;

  vec_t tbl[9];

  // Model state for the randomised run
  logic [4:0]  m_addr;
  logic        m_db;
  logic        swq[$];
  logic        sq[$];
  logic [13:0] rom[32];

  function automatic logic [13:0] br(input logic c, input logic [7:0] imm);
    logic [13:0] v;
    v = {2'b11, 4'b0000, imm};
    v[7] = c;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b1; I = ADD;
    tick();
    reset = 1'b0;
  endtask

  task automatic model_reset();
    m_addr = '0; m_db = 1'b0;
    swq.delete(); sq.delete();
    for (int k = 0; k < SS; k++) swq.push_back(1'b0);
    for (int k = 0; k < DB; k++) sq.push_back(1'b0);
  endtask

  // One clock edge of the behavioural model; uses pre-edge debounced level
  task automatic model_step(input logic r, input logic [13:0] ins, input logic sg, input logic e);
    logic s, tk, all_diff;
    if (r) begin
      model_reset();
    end else begin
      s  = swq[0];
      tk = (ins[13:12] == 2'b11) && (m_db == ins[7]);
      if (e) m_addr = tk ? ins[4:0] : 5'(m_addr + 1);
      sq.push_back(s); void'(sq.pop_front());
      all_diff = 1'b1;
      foreach (sq[k]) if (sq[k] == m_db) all_diff = 1'b0;
      if (all_diff) m_db = ~m_db;
      swq.push_back(sg); void'(swq.pop_front());
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; sw_go = 1'b1; I = ADD;

    // Reset with switch high: state cleared after first edge, held through second
    tick();
    chk("rst_addr", address, 0);
    chk("rst_db", sw_db, 0);
    tick();
    chk("rst2_addr", address, 0);
    chk("rst2_db", sw_db, 0);
    reset = 1'b0; sw_go = 1'b0;

    // Directed table, switch low so sw_db stays 0
    tbl[0] = '{1'b0, 1'b1, 1'b0, ADD,                     1'b0, 1'b0, 5'd1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, ADD,                     1'b0, 1'b0, 5'd1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, br(1'b0, 8'd5),          1'b1, 1'b0, 5'd5, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, br(1'b1, 8'd9),          1'b0, 1'b0, 5'd6, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, br(1'b0, 8'd6),          1'b1, 1'b1, 5'd6, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, br(1'b0, 8'd6),          1'b1, 1'b1, 5'd6, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 14'h2FFF,                1'b0, 1'b0, 5'd7, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 14'h1FFF,                1'b0, 1'b0, 5'd8, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, br(1'b0, 8'b0110_0011),  1'b1, 1'b0, 5'd3, 1'b0};
    for (int v = 0; v < 9; v++) begin
      reset = tbl[v].rst; en = tbl[v].en; sw_go = tbl[v].sw; I = tbl[v].ins;
      #1;
      chk($sformatf("tbl%0d_taken", v), branch_taken, tbl[v].exp_tk);
      chk($sformatf("tbl%0d_spin", v), spin, tbl[v].exp_sp);
      tick();
      chk($sformatf("tbl%0d_addr", v), address, tbl[v].exp_addr);
      chk($sformatf("tbl%0d_db", v), sw_db, tbl[v].exp_db);
    end

    // Wrap: 40 ADD steps from reset
    sw_go = 1'b0; do_reset();
    for (int c = 1; c <= 40; c++) begin
      I = ADD; en = 1'b1;
      #1;
      chk("wrap_taken", branch_taken, 0);
      tick();
      chk($sformatf("wrap%0d_addr", c), address, c % 32);
    end

    // Self-branch spin released by a clean switch step
    sw_go = 1'b0; do_reset();
    I = ADD; tick();
    I = br(1'b0, 8'd1);
    #1;
    chk("spin_on", spin, 1);
    for (int c = 0; c < 3; c++) tick();
    chk("spin_hold_addr", address, 1);
    sw_go = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    chk("spin_db_early", sw_db, 0);
    chk("spin_addr_early", address, 1);
    tick();
    chk("spin_db_t6", sw_db, 1);
    chk("spin_addr_t6", address, 1);
    chk("spin_off", spin, 0);
    tick();
    chk("spin_addr_t7", address, 2);

    // Glitch shorter than DB_CYCLES is rejected
    sw_go = 1'b0; do_reset();
    I = ADD; tick();
    I = br(1'b0, 8'd1);
    sw_go = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    sw_go = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("glitch_db", sw_db, 0);
    end
    chk("glitch_addr", address, 1);
    chk("glitch_spin", spin, 1);

    // en=0 holds PC while the debouncer keeps running
    sw_go = 1'b0; do_reset();
    I = ADD;
    for (int c = 0; c < 9; c++) tick();
    chk("hold_start", address, 9);
    en = 1'b0; sw_go = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("hold_addr", address, 9);
    chk("hold_db", sw_db, 1);
    en = 1'b1;

    // Reset mid-spin with sw_db=1
    sw_go = 1'b1; do_reset();
    I = ADD;
    for (int c = 0; c < 8; c++) tick();
    chk("rs_pre_addr", address, 8);
    chk("rs_pre_db", sw_db, 1);
    I = br(1'b1, 8'd8);
    #1;
    chk("rs_spin", spin, 1);
    tick();
    chk("rs_spin_addr", address, 8);
    reset = 1'b1;
    tick();
    chk("rs_addr", address, 0);
    chk("rs_db", sw_db, 0);
    reset = 1'b0; sw_go = 1'b0;

    // Randomised run against the model; ROM heavy in branches
    for (int k = 0; k < 32; k++) begin
      case ($urandom_range(0, 3))
        0:       rom[k] = 14'($urandom);
        default: rom[k] = br(1'($urandom), 8'($urandom_range(0, 255)));
      endcase
    end
    do_reset(); model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic r_v, e_v, tk_e;
      r_v = ($urandom_range(0, 199) == 0);
      e_v = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) sw_go = ~sw_go;
      reset = r_v; en = e_v; I = rom[m_addr];
      #1;
      tk_e = (I[13:12] == 2'b11) && (m_db == I[7]);
      chk("rnd_taken", branch_taken, tk_e);
      chk("rnd_spin", spin, tk_e && (I[4:0] == m_addr));
      model_step(r_v, I, sw_go, e_v);
      tick();
      chk("rnd_addr", address, m_addr);
      chk("rnd_db", sw_db, m_db);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
